prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 104 ++++++++++
 tb/tb_prod_accum.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// prod_accum: frame accumulator for 32-bit products from the 16x16 shift-add
// multiplier. It sums up to 256 products per frame into a 36-bit
// accumulator and presents sum, count and a sticky overflow flag until
// downstream accepts them.
// Optional build macro: PROD_ACCUM_SATURATE_EN. When defined, the
// accumulator clamps at all-ones on overflow. By default it wraps modulo 2^36.
module prod_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_prod,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] out_sum,
  output logic [8:0]  out_count,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [35:0] acc, acc_nxt;
  logic [8:0]  count, count_nxt;
  logic        ovf, ovf_nxt;

  logic        take;
  logic        give;
  logic        close;
  logic        carry_ovf;
  logic [36:0] add_sum;

  // Handshake decode, adder and result gating; ready/valid come from state only
  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
    take      = in_valid && in_ready;
    give      = out_valid && out_ready;
    add_sum   = {1'b0, acc} + {5'b0, in_prod};
    carry_ovf = ovf || add_sum[36];
    // The 256th product closes the frame even without in_last
    close     = in_last || (count == 9'd255);
    out_sum   = out_valid ? acc   : '0;
    out_count = out_valid ? count : '0;
    out_ovf   = out_valid ? ovf   : 1'b0;
  end

  // Next-state logic: accumulate on transfers, clear when the result is taken
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE, ACCUM: begin
        if (take) begin
          count_nxt = count + 9'd1;
          ovf_nxt   = carry_ovf;
`ifdef PROD_ACCUM_SATURATE_EN
          acc_nxt   = carry_ovf ? '1 : add_sum[35:0];
`else
          acc_nxt   = add_sum[35:0];
`endif
          state_nxt = close ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (give) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        count_nxt = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: self-checking bench for prod_accum. A frame-level reference
// model keeps the exact running total and product count of the current
// frame. Expected outputs are derived from that total by plain arithmetic.
module tb_prod_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_sum;
  logic [8:0]  out_count;
  logic        out_ovf;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: exact frame total, product count, result-pending flag
  longint unsigned m_total;
  int unsigned     m_count;
  bit              m_hold;

  localparam longint unsigned LIM = 64'h10_0000_0000;

  prod_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_sum();
`ifdef PROD_ACCUM_SATURATE_EN
    return (m_total >= LIM) ? 64'hF_FFFF_FFFF : m_total;
`else
    return m_total % LIM;
`endif
  endfunction

  task automatic model_clear();
    m_total = 0;
    m_count = 0;
    m_hold  = 1'b0;
  endtask

  // Called on a falling edge; returns on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
  endtask

  task automatic xfer(input logic [31:0] p, input logic l);
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(posedge clk);
    m_total += p;
    m_count++;
    m_hold = l || (m_count == 256);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("xfer_out_valid", out_valid, m_hold);
    chk("xfer_in_ready", in_ready, !m_hold);
    if (!m_hold) chk("xfer_sum_gated", out_sum, 0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, exp_sum());
    chk({tag, "_count"}, out_count, m_count);
    chk({tag, "_ovf"}, out_ovf, m_total >= LIM);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_sum", out_sum, 0);
    chk("drain_count", out_count, 0);
    chk("drain_ovf", out_ovf, 0);
  endtask

  initial begin
    int unsigned len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single-product frame, one cycle of latency
    xfer(32'h0000_0006, 1'b1);
    check_result("single");
    chk("single_sum_k", out_sum, 36'h6);
    chk("single_count_k", out_count, 1);
    chk("single_ovf_k", out_ovf, 0);
    drain();

    // Back-to-back transfers
    xfer(32'hFFFE_0001, 1'b0);
    xfer(32'h0000_0003, 1'b0);
    xfer(32'h0000_0010, 1'b1);
    check_result("b2b");
    chk("b2b_sum_k", out_sum, 36'h0_FFFE_0014);
    chk("b2b_count_k", out_count, 3);

    // Backpressure in HOLD with upstream offering a product
    in_valid = 1'b1;
    in_prod  = 32'h1234_5678;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", out_sum, 36'h0_FFFE_0014);
      chk("bp_count", out_count, 3);
      chk("bp_ovf", out_ovf, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();

    // Overflow: 17 large products
    for (int i = 0; i < 17; i++) xfer(32'hFFFE_0001, (i == 16));
    check_result("ovf");
    chk("ovf_flag_k", out_ovf, 1);
    chk("ovf_count_k", out_count, 17);
`ifdef PROD_ACCUM_SATURATE_EN
    chk("ovf_sum_k", out_sum, 36'hF_FFFF_FFFF);
`else
    chk("ovf_sum_k", out_sum, 36'h0_FFDE_0011);
`endif
    drain();

    // Forced close at 256 products
    for (int i = 0; i < 256; i++) xfer(32'h1, 1'b0);
    check_result("force");
    chk("force_sum_k", out_sum, 36'h100);
    chk("force_count_k", out_count, 256);
    drain();

    // Reset mid-frame discards the partial frame
    xfer(32'h5, 1'b0);
    xfer(32'h5, 1'b0);
    do_reset();
    xfer(32'h7, 1'b1);
    check_result("midrst");
    chk("midrst_sum_k", out_sum, 36'h7);
    chk("midrst_count_k", out_count, 1);
    drain();

    // Reset while holding a result
    xfer(32'h9, 1'b1);
    do_reset();

    // Random frames with idle gaps and random backpressure
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 24);
      for (int k = 0; k < int'(len); k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_prod  = $urandom;
          in_last  = 1'b1;
          @(posedge clk);
          @(negedge clk);
          in_last = 1'b0;
          chk("gap_out_valid", out_valid, 0);
        end
        xfer(($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 255) : $urandom,
             (k == int'(len) - 1));
      end
      check_result("rand");
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        @(posedge clk);
        @(negedge clk);
        chk("rand_hold_sum", out_sum, exp_sum());
        chk("rand_hold_count", out_count, m_count);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
